// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared types and constants for the ARM rotated-immediate
//               encoder (immediate field layout, FSM states, rotation count).
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // Number of even rotations examined per search pass
    localparam int IMM_ROT_STEPS = 16;

    // Operand-2 immediate field: value = ROR(imm8, 2*rot)
    typedef struct packed {
        logic [3:0] rot;
        logic [7:0] imm8;
    } imm12_t;

    // Encoder control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/rol32.sv
`default_nettype none
// ============================================================================
// Module      : rol32
// Description : Combinational 32-bit rotate-left by a 5-bit amount.
// Revision    : 1.0 - initial release
// ============================================================================
module rol32 (
    input  logic [31:0] value,
    input  logic [4:0]  amount,
    output logic [31:0] result
);

    logic [63:0] doubled;

    // Shift a doubled copy left so the bits leaving bit 31 land back at bit 0
    always_comb begin
        doubled = {value, value} << amount;
        result  = doubled[63:32];
    end

endmodule
`default_nettype wire

// File: rtl/arm_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : arm_imm_encoder
// Description : Iterative encoder for ARM rotated immediates. Searches the 16
//               even rotations of a 32-bit constant, one per clock, and
//               returns {rot, imm8} plus a found flag.
//               Optional macro IMM_ENC_INVERT_EN adds a second pass on the
//               bitwise inverse (MVN/BIC form) and drives out_inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_imm_encoder
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_imm12,
    output logic        out_found,
    output logic        out_inverted
);

    localparam logic [3:0] ROT_LAST = 4'(IMM_ROT_STEPS - 1);

    enc_state_t  state;
    enc_state_t  state_nx;
    logic [31:0] cand;
    logic [3:0]  rot;
    logic [31:0] rotated;
    imm12_t      imm_q;
    logic        found_q;
    logic        match;
    logic        last_rot;
    logic        retry;
    logic        accept;

    // ROL by 2*rot undoes the ROR of the decode, exposing imm8 in the low byte
    rol32 u_rol32 (
        .value  (cand),
        .amount ({rot, 1'b0}),
        .result (rotated)
    );

    assign match    = (rotated[31:8] == 24'd0);
    assign last_rot = (rot == ROT_LAST);
    assign accept   = in_valid && (state == IDLE);

`ifdef IMM_ENC_INVERT_EN
    logic inv;
    logic inv_q;

    assign retry = last_rot && !inv;

    // Pass flag: cleared on accept, set when restarting on the inverted value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv   <= 1'b0;
            inv_q <= 1'b0;
        end else if (accept) begin
            inv <= 1'b0;
        end else if (state == SEARCH) begin
            if (match) begin
                inv_q <= inv;
            end else if (retry) begin
                inv <= 1'b1;
            end else if (last_rot) begin
                inv_q <= 1'b0;
            end
        end
    end

    assign out_inverted = inv_q;
`else
    assign retry        = 1'b0;
    assign out_inverted = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)                     state_nx = SEARCH;
            SEARCH:  if (match || (last_rot && !retry)) state_nx = DONE;
            DONE:    if (out_ready)                    state_nx = IDLE;
            default:                                   state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Search datapath: candidate, rotation counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand    <= 32'd0;
            rot     <= 4'd0;
            imm_q   <= '0;
            found_q <= 1'b0;
        end else if (accept) begin
            cand <= in_value;
            rot  <= 4'd0;
        end else if (state == SEARCH) begin
            if (match) begin
                imm_q   <= '{rot: rot, imm8: rotated[7:0]};
                found_q <= 1'b1;
            end else if (!last_rot) begin
                rot <= rot + 4'd1;
            end else if (retry) begin
                cand <= ~cand;
                rot  <= 4'd0;
            end else begin
                imm_q   <= '0;
                found_q <= 1'b0;
            end
        end
    end

    assign out_imm12 = imm_q;
    assign out_found = found_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_imm_encoder
// Description : Self-checking bench for arm_imm_encoder. Expected results come
//               from a brute-force decode search over all 4096 immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_imm12;
    logic        out_found;
    logic        out_inverted;

    int n_checks = 0;
    int n_fail   = 0;

    arm_imm_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm12    (out_imm12),
        .out_found    (out_found),
        .out_inverted (out_inverted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Decode every immediate in rotation order; first hit is the lowest rot
    function automatic int find_enc(input logic [31:0] v);
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 256; i++)
                if (ror32(32'(i), 2 * r) == v) return r * 256 + i;
        return -1;
    endfunction

    task automatic model(input logic [31:0] v, output logic found, output logic [11:0] imm,
                         output logic inv, output int lat);
        int e;
        found = 1'b0; imm = 12'h000; inv = 1'b0;
        e = find_enc(v);
        if (e >= 0) begin
            found = 1'b1; imm = 12'(e); lat = e / 256 + 1;
            return;
        end
`ifdef IMM_ENC_INVERT_EN
        e = find_enc(~v);
        if (e >= 0) begin
            found = 1'b1; imm = 12'(e); inv = 1'b1; lat = 17 + e / 256;
            return;
        end
        lat = 32;
`else
        lat = 16;
`endif
    endtask

    task automatic run_case(input logic [31:0] v, input int hold);
        logic        e_found, e_inv;
        logic [11:0] e_imm;
        int          e_lat, lat;
        logic        got;
        model(v, e_found, e_imm, e_inv, e_lat);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check("out_valid_timeout", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("found", 32'(out_found), 32'(e_found));
        check("imm12", 32'(out_imm12), 32'(e_imm));
        check("inverted", 32'(out_inverted), 32'(e_inv));
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                in_valid = 1'b1;
                in_value = $urandom;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_imm12", 32'(out_imm12), 32'(e_imm));
            check("hold_found", 32'(out_found), 32'(e_found));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          kind;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imm12", 32'(out_imm12), 32'd0);
        check("rst_found", 32'(out_found), 32'd0);
        check("rst_inverted", 32'(out_inverted), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_case(32'h000000FF, 0);
        run_case(32'h00000000, 0);
        run_case(32'hFF000000, 0);
        run_case(32'hF000000F, 0);
        run_case(32'h000003FC, 0);
        run_case(32'h00000101, 0);
        run_case(32'hFFFFFF00, 0);
        run_case(32'h00000FF0, 5);
        run_case(32'h0000AB00, 0);

        // Reset during a search that would finish at rot 10
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'h000FF000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_imm12", 32'(out_imm12), 32'd0);
        check("midrst_found", 32'(out_found), 32'd0);
        check("midrst_inverted", 32'(out_inverted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case(32'h000000FF, 0);

        // Randomized mix of encodable, inverted-encodable and arbitrary values
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            if (kind == 1) v = ~v;
            else if (kind == 2) v = $urandom;
            run_case(v, (n % 8 == 3) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
